// File: rtl/color_pkg.sv
// Shared types and constants for the color_pipe escape-count-to-RGB mapper.
package color_pkg;

    localparam int HUE_W   = 9;
    localparam int RECIP60 = 1093;

    typedef enum logic [2:0] {
        SECT0 = 3'd0,
        SECT1 = 3'd1,
        SECT2 = 3'd2,
        SECT3 = 3'd3,
        SECT4 = 3'd4,
        SECT5 = 3'd5
    } sector_t;

    typedef struct packed {
        logic             valid;
        logic             inset;
        logic             mode;
        logic [HUE_W-1:0] hue;
    } s1_t;

    typedef struct packed {
        logic    valid;
        logic    inset;
        logic    mode;
        sector_t sector;
        logic [5:0] rem;
    } s2_t;

    typedef struct packed {
        logic    valid;
        logic    inset;
        logic    mode;
        sector_t sector;
    } s3_t;

    // Sum of two 9-bit angles is at most 1022, so two conditional subtractions reach 0..359.
    function automatic logic [HUE_W-1:0] hue_wrap(input logic [HUE_W:0] sum);
        logic [HUE_W:0] s;
        s = sum;
        if (s >= 10'd360) s = s - 10'd360;
        else              s = s;
        if (s >= 10'd360) s = s - 10'd360;
        else              s = s;
        return s[HUE_W-1:0];
    endfunction

endpackage

// File: rtl/color_pipe_log2_approx.sv
// Combinational leading-one position plus the 4 bits just below it (log2 mantissa).
module log2_approx #(
    parameter int IN_W = 9,
    parameter int P_W  = 4
) (
    input  logic [IN_W-1:0] x,
    output logic [P_W-1:0]  p,
    output logic [3:0]      frac
);

    logic [IN_W+3:0] ext_s;
    logic [IN_W+3:0] norm_s;

    // Highest set bit wins; the normalising shift then exposes the fraction bits.
    always_comb begin
        p = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (x[i]) p = P_W'(i);
            else      p = p;
        end
        ext_s  = {x, 4'b0000};
        norm_s = ext_s << (IN_W - 1 - int'(p));
        frac   = norm_s[IN_W+2 -: 4];
    end

endmodule

// File: rtl/color_pipe.sv
// Four-stage escape-count to RGB mapper (HSV with S=1, or grayscale).
// Define COLOR_LOG_EN to use a log-scaled value curve instead of the linear one.
module color_pipe
    import color_pkg::*;
#(
    parameter int ITER_W   = 8,
    parameter int MAX_ITER = 100,
    parameter int COLOR_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ITER_W-1:0]  in_iter,
    input  logic [HUE_W-1:0]   in_hue,
    input  logic [HUE_W-1:0]   in_hue_ofs,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COLOR_W-1:0] out_r,
    output logic [COLOR_W-1:0] out_g,
    output logic [COLOR_W-1:0] out_b
);

    localparam logic [63:0]       CMAX       = (64'd1 << COLOR_W) - 64'd1;
    localparam logic [COLOR_W-1:0] VMAX      = {COLOR_W{1'b1}};
    localparam logic [ITER_W:0]   MAX_ITER_V = (ITER_W+1)'(MAX_ITER);
    localparam int                RP_W       = COLOR_W + 17;

    logic               adv_s;
    s1_t                s1_next_s, s1_r;
    s2_t                s2_next_s, s2_r;
    s3_t                s3_r;
    logic [COLOR_W-1:0] v_next_s, v1_r, v2_r, v3_r;
    logic [COLOR_W-1:0] x_next_s, x3_r;
    logic [HUE_W-1:0]   base_s;
    logic [5:0]         f_s;
    logic [RP_W-1:0]    ramp_prod_s, ramp_sh_s;
    logic [COLOR_W-1:0] r_s, g_s, b_s;

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

`ifdef COLOR_LOG_EN
    localparam int          P_W    = $clog2(ITER_W + 1);
    localparam logic [63:0] VSCALE = (CMAX * 64'd65536 + 64'(ITER_W * 16) - 64'd1) / 64'(ITER_W * 16);

    logic [ITER_W:0] iter_p1_s;
    logic [P_W-1:0]  lead_s;
    logic [3:0]      frac_s;
    logic [63:0]     val_prod_s, val_sh_s;

    assign iter_p1_s = {1'b0, in_iter} + {{ITER_W{1'b0}}, 1'b1};

    log2_approx #(.IN_W(ITER_W + 1), .P_W(P_W)) u_log2 (
        .x    (iter_p1_s),
        .p    (lead_s),
        .frac (frac_s)
    );

    // Log-curve value from L = {p, frac}.
    always_comb begin
        val_prod_s = {{(60-P_W){1'b0}}, lead_s, frac_s} * VSCALE;
        val_sh_s   = val_prod_s >> 16;
        if (val_sh_s > CMAX) v_next_s = VMAX;
        else                 v_next_s = val_sh_s[COLOR_W-1:0];
    end
`else
    localparam logic [63:0] LSCALE = (CMAX * 64'd65536 + 64'(MAX_ITER) - 64'd1) / 64'(MAX_ITER);

    logic [63:0] val_prod_s, val_sh_s;

    // Linear value from the raw iteration count.
    always_comb begin
        val_prod_s = {{(64-ITER_W){1'b0}}, in_iter} * LSCALE;
        val_sh_s   = val_prod_s >> 16;
        if (val_sh_s > CMAX) v_next_s = VMAX;
        else                 v_next_s = val_sh_s[COLOR_W-1:0];
    end
`endif

    // Stage 1 payload: in-set flag and hue folded into 0..359.
    always_comb begin
        s1_next_s.valid = in_valid;
        s1_next_s.inset = ({1'b0, in_iter} >= MAX_ITER_V);
        s1_next_s.mode  = in_mode;
        s1_next_s.hue   = hue_wrap({1'b0, in_hue} + {1'b0, in_hue_ofs});
    end

    // Stage 2: 60-degree sector by compare chain and remainder within it.
    always_comb begin
        s2_next_s.valid = s1_r.valid;
        s2_next_s.inset = s1_r.inset;
        s2_next_s.mode  = s1_r.mode;
        if (s1_r.hue < 9'd60) begin
            s2_next_s.sector = SECT0; base_s = 9'd0;
        end else if (s1_r.hue < 9'd120) begin
            s2_next_s.sector = SECT1; base_s = 9'd60;
        end else if (s1_r.hue < 9'd180) begin
            s2_next_s.sector = SECT2; base_s = 9'd120;
        end else if (s1_r.hue < 9'd240) begin
            s2_next_s.sector = SECT3; base_s = 9'd180;
        end else if (s1_r.hue < 9'd300) begin
            s2_next_s.sector = SECT4; base_s = 9'd240;
        end else begin
            s2_next_s.sector = SECT5; base_s = 9'd300;
        end
        s2_next_s.rem = 6'(s1_r.hue - base_s);
    end

    // Stage 3: ramp X = v*f/60 in fixed point, clamped to v against rounding overshoot.
    always_comb begin
        if (s2_r.sector[0]) f_s = 6'd60 - s2_r.rem;
        else                f_s = s2_r.rem;
        ramp_prod_s = RP_W'(v2_r) * RP_W'(f_s) * RP_W'(RECIP60);
        ramp_sh_s   = ramp_prod_s >> 16;
        if (ramp_sh_s > RP_W'(v2_r)) x_next_s = v2_r;
        else                         x_next_s = ramp_sh_s[COLOR_W-1:0];
    end

    // Stage 4: channel mux; in-set overrides grayscale, which overrides hue.
    always_comb begin
        r_s = '0;
        g_s = '0;
        b_s = '0;
        if (s3_r.inset) begin
            r_s = '0; g_s = '0; b_s = '0;
        end else if (s3_r.mode) begin
            r_s = v3_r; g_s = v3_r; b_s = v3_r;
        end else begin
            case (s3_r.sector)
                SECT0:   begin r_s = v3_r; g_s = x3_r; b_s = '0;   end
                SECT1:   begin r_s = x3_r; g_s = v3_r; b_s = '0;   end
                SECT2:   begin r_s = '0;   g_s = v3_r; b_s = x3_r; end
                SECT3:   begin r_s = '0;   g_s = x3_r; b_s = v3_r; end
                SECT4:   begin r_s = x3_r; g_s = '0;   b_s = v3_r; end
                SECT5:   begin r_s = v3_r; g_s = '0;   b_s = x3_r; end
                default: begin r_s = '0;   g_s = '0;   b_s = '0;   end
            endcase
        end
    end

    // Whole pipeline moves in lockstep on adv; reset drops every in-flight beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_r      <= '0;
            s2_r      <= '0;
            s3_r      <= '0;
            v1_r      <= '0;
            v2_r      <= '0;
            v3_r      <= '0;
            x3_r      <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
        end else if (adv_s) begin
            s1_r      <= s1_next_s;
            v1_r      <= v_next_s;
            s2_r      <= s2_next_s;
            v2_r      <= v1_r;
            s3_r      <= '{valid: s2_r.valid, inset: s2_r.inset, mode: s2_r.mode, sector: s2_r.sector};
            v3_r      <= v2_r;
            x3_r      <= x_next_s;
            out_valid <= s3_r.valid;
            out_r     <= r_s;
            out_g     <= g_s;
            out_b     <= b_s;
        end
    end

endmodule

// File: tb/tb_color_pipe.sv
// Table-driven scoreboard bench for color_pipe (default linear build).
module tb_color_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_iter;
    logic [8:0] in_hue;
    logic [8:0] in_hue_ofs;
    logic       in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r, out_g, out_b;

    color_pipe #(.ITER_W(8), .MAX_ITER(100), .COLOR_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_iter    (in_iter),
        .in_hue     (in_hue),
        .in_hue_ofs (in_hue_ofs),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] iter;
        logic [8:0] hue;
        logic [8:0] ofs;
        logic       mode;
        logic [7:0] r, g, b;
    } vec_t;

    localparam int NV = 17;
    vec_t        tbl [NV];
    logic [23:0] sb [$];
    int          nvec = 0;
    int          nmis = 0;
    int          stall_seen = 0;

    logic        prev_stall = 1'b0;
    logic [23:0] prev_rgb   = 24'd0;

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: pop and compare each delivered beat; check stall stability and backpressure.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (prev_stall) begin
                nvec++;
                if ({out_r, out_g, out_b} !== prev_rgb || out_valid !== 1'b1) begin
                    nmis++;
                    $display("FAIL stall_hold: got %h expected %h", {out_r, out_g, out_b}, prev_rgb);
                end
            end
            if (out_valid && !out_ready) begin
                stall_seen++;
                nvec++;
                if (in_ready !== 1'b0) begin
                    nmis++;
                    $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                nvec++;
                if (sb.size() == 0) begin
                    nmis++;
                    $display("FAIL unexpected_beat: got %0d,%0d,%0d expected none", out_r, out_g, out_b);
                end else begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    if ({out_r, out_g, out_b} !== e) begin
                        nmis++;
                        $display("FAIL pixel: got %0d,%0d,%0d expected %0d,%0d,%0d",
                                 out_r, out_g, out_b, e[23:16], e[15:8], e[7:0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_rgb   = {out_r, out_g, out_b};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input int idx);
        @(negedge clk);
        in_valid   = 1'b1;
        in_iter    = tbl[idx].iter;
        in_hue     = tbl[idx].hue;
        in_hue_ofs = tbl[idx].ofs;
        in_mode    = tbl[idx].mode;
        for (int t = 0; t < 20; t++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (in_ready) begin
            sb.push_back({tbl[idx].r, tbl[idx].g, tbl[idx].b});
        end else begin
            chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 50; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        tbl[0]  = '{8'd50,  9'd0,   9'd0,   1'b0, 8'd127, 8'd0,   8'd0};
        tbl[1]  = '{8'd50,  9'd30,  9'd0,   1'b0, 8'd127, 8'd63,  8'd0};
        tbl[2]  = '{8'd50,  9'd120, 9'd0,   1'b0, 8'd0,   8'd127, 8'd0};
        tbl[3]  = '{8'd50,  9'd350, 9'd20,  1'b0, 8'd127, 8'd21,  8'd0};
        tbl[4]  = '{8'd50,  9'd511, 9'd511, 1'b0, 8'd127, 8'd0,   8'd122};
        tbl[5]  = '{8'd100, 9'd200, 9'd0,   1'b0, 8'd0,   8'd0,   8'd0};
        tbl[6]  = '{8'd255, 9'd45,  9'd0,   1'b1, 8'd0,   8'd0,   8'd0};
        tbl[7]  = '{8'd99,  9'd0,   9'd0,   1'b1, 8'd252, 8'd252, 8'd252};
        tbl[8]  = '{8'd0,   9'd90,  9'd0,   1'b0, 8'd0,   8'd0,   8'd0};
        tbl[9]  = '{8'd50,  9'd180, 9'd0,   1'b0, 8'd0,   8'd127, 8'd127};
        tbl[10] = '{8'd50,  9'd240, 9'd0,   1'b0, 8'd0,   8'd0,   8'd127};
        tbl[11] = '{8'd50,  9'd359, 9'd0,   1'b0, 8'd127, 8'd0,   8'd2};
        tbl[12] = '{8'd99,  9'd60,  9'd0,   1'b0, 8'd252, 8'd252, 8'd0};
        tbl[13] = '{8'd25,  9'd100, 9'd0,   1'b0, 8'd21,  8'd63,  8'd0};
        tbl[14] = '{8'd50,  9'd0,   9'd300, 1'b0, 8'd127, 8'd0,   8'd127};
        tbl[15] = '{8'd50,  9'd200, 9'd0,   1'b1, 8'd127, 8'd127, 8'd127};
        tbl[16] = '{8'd1,   9'd0,   9'd0,   1'b0, 8'd2,   8'd0,   8'd0};

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_iter    = 8'd0;
        in_hue     = 9'd0;
        in_hue_ofs = 9'd0;
        in_mode    = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_rgb", int'({out_r, out_g, out_b}), 0);
        reset_n = 1'b1;
        #1;
        chk("reset_in_ready", int'(in_ready), 1);

        // Latency: single beat must appear on the 4th negedge after its accept edge.
        send(0);
        idle();
        begin
            int k;
            k = 1;
            while (k < 12 && !out_valid) begin
                @(negedge clk);
                k++;
            end
            chk("latency", k, 4);
        end
        drain();

        // Full-rate table sweep.
        for (int i = 0; i < NV; i++) send(i);
        idle();
        drain();

        // Six back-to-back beats with a 3-cycle downstream stall mid-stream.
        fork
            begin
                for (int i = 0; i < 6; i++) send(i);
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_observed", int'(stall_seen >= 2), 1);

        // Reset with three beats in flight: nothing may emerge afterwards.
        send(1);
        send(2);
        send(3);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        sb.delete();
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_rgb", int'({out_r, out_g, out_b}), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int t = 0; t < 8; t++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("no_stale_beat", seen, 0);
        end
        chk("post_reset_in_ready", int'(in_ready), 1);

        // Pipeline still works after the mid-stream reset.
        send(13);
        send(4);
        idle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
